// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot/run sequencer.
package prog_loader_pkg;

    localparam int unsigned ByteW        = 8;
    localparam int unsigned DefaultLanes = 4;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StRun,
        StDump,
        StDone
    } state_e;

    function automatic logic is_busy(input state_e s);
        return s inside {StClear, StLoad, StRun, StDump};
    endfunction

endpackage

// File: rtl/prog_loader_cnt.sv
// Up-counter with synchronous clear and enable; wraps to zero after reaching MAX.
module prog_loader_cnt #(
    parameter int unsigned W   = 8,
    parameter int unsigned MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         last
);

    assign last = (count == W'(MAX));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot/run sequencer: clears program memory, streams an image in, runs the core for a fixed
// budget, then reads back a result window. Port outputs are registered images of the state.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned LANES      = DefaultLanes,
    parameter int unsigned AW         = 20,
    parameter int unsigned MAX_BYTES  = 420,
    parameter int unsigned RUN_CYCLES = 8000,
    parameter int unsigned DUMP_BASE  = 64,
    parameter int unsigned DUMP_WORDS = 2,
    parameter bit          CLEAR_EN   = 1'b1,
    localparam int unsigned BW        = $clog2(MAX_BYTES + 1),
    localparam int unsigned DW        = $clog2(DUMP_WORDS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   byte_valid,
    input  logic [ByteW-1:0]       byte_data,
    input  logic                   byte_last,
    output logic                   byte_ready,
    output logic                   mem_own,
    output logic [AW-1:0]          mem_addr,
    output logic [LANES-1:0]       mem_we,
    output logic [ByteW*LANES-1:0] mem_wdata,
    output logic                   mem_re,
    input  logic [ByteW*LANES-1:0] mem_rdata,
    output logic                   core_rst,
    output logic                   core_clk_en,
    output logic                   busy,
    output logic                   done,
    output logic                   dump_valid,
    output logic [AW-1:0]          dump_addr,
    output logic [ByteW*LANES-1:0] dump_data,
    output logic [BW-1:0]          bytes_loaded,
    output logic [31:0]            cycle_count
);

    state_e state_q;

    logic          start_ok;
    logic [AW-1:0] clr_addr;
    logic          clr_last;
    logic [BW-1:0] byte_idx;
    logic          byte_idx_last;
    logic [31:0]   run_cnt;
    logic          run_last;
    logic [DW-1:0] dump_idx;
    logic          dump_last;

    // Read pipeline: request visible -> data returns -> captured into dump_data.
    logic          issued_q;
    logic          re_last_q;
    logic          re_d1_q;
    logic          last_d1_q;
    logic [AW-1:0] addr_d1_q;

    assign byte_ready = (state_q == StLoad);
    assign start_ok   = start && (state_q == StIdle || state_q == StDone);

    prog_loader_cnt #(.W(AW), .MAX((1 << AW) - 1)) u_clr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .en    (state_q == StClear),
        .count (clr_addr),
        .last  (clr_last)
    );

    prog_loader_cnt #(.W(BW), .MAX(MAX_BYTES - 1)) u_byte_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .en    (byte_valid && byte_ready),
        .count (byte_idx),
        .last  (byte_idx_last)
    );

    prog_loader_cnt #(.W(32), .MAX(RUN_CYCLES - 1)) u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .en    (state_q == StRun),
        .count (run_cnt),
        .last  (run_last)
    );

    prog_loader_cnt #(.W(DW), .MAX(DUMP_WORDS - 1)) u_dump_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .en    (state_q == StDump && !issued_q),
        .count (dump_idx),
        .last  (dump_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            mem_own      <= 1'b1;
            core_rst     <= 1'b1;
            core_clk_en  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mem_addr     <= '0;
            mem_we       <= '0;
            mem_wdata    <= '0;
            mem_re       <= 1'b0;
            dump_valid   <= 1'b0;
            dump_addr    <= '0;
            dump_data    <= '0;
            bytes_loaded <= '0;
            cycle_count  <= '0;
            issued_q     <= 1'b0;
            re_last_q    <= 1'b0;
            re_d1_q      <= 1'b0;
            last_d1_q    <= 1'b0;
            addr_d1_q    <= '0;
        end else begin
            mem_own     <= (state_q != StRun);
            core_rst    <= (state_q != StRun);
            core_clk_en <= (state_q == StRun);
            busy        <= is_busy(state_q);
            done        <= (state_q == StDone);
            mem_we      <= '0;
            mem_re      <= 1'b0;
            re_last_q   <= 1'b0;
            re_d1_q     <= mem_re;
            last_d1_q   <= re_last_q;
            addr_d1_q   <= mem_addr;
            dump_valid  <= re_d1_q;
            if (re_d1_q) begin
                dump_data <= mem_rdata;
                dump_addr <= addr_d1_q;
            end

            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q      <= CLEAR_EN ? StClear : StLoad;
                        bytes_loaded <= '0;
                        issued_q     <= 1'b0;
                    end
                end
                StClear: begin
                    mem_we    <= '1;
                    mem_addr  <= clr_addr;
                    mem_wdata <= '0;
                    if (clr_last) state_q <= StLoad;
                end
                StLoad: begin
                    if (byte_valid) begin
                        mem_we       <= LANES'(1) << (byte_idx % BW'(LANES));
                        mem_addr     <= AW'(byte_idx / BW'(LANES));
                        mem_wdata    <= {LANES{byte_data}};
                        bytes_loaded <= byte_idx + BW'(1);
                        if (byte_last || byte_idx_last) begin
                            state_q     <= StRun;
                            cycle_count <= '0;
                        end
                    end
                end
                StRun: begin
                    cycle_count <= run_cnt + 32'd1;
                    if (run_last) state_q <= StDump;
                end
                StDump: begin
                    if (!issued_q) begin
                        mem_re    <= 1'b1;
                        mem_addr  <= AW'(DUMP_BASE) + AW'(dump_idx);
                        re_last_q <= dump_last;
                        issued_q  <= dump_last;
                    end
                    // Leave only once the final word is being captured.
                    if (last_d1_q) state_q <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader with a memory model, image-based reference and dump scoreboard.
module tb_prog_loader;

    localparam int unsigned LANES      = 4;
    localparam int unsigned AW         = 7;
    localparam int unsigned WORDS      = 1 << AW;
    localparam int unsigned MAX_BYTES  = 420;
    localparam int unsigned RUN_CYCLES = 10;
    localparam int unsigned DUMP_BASE  = 64;
    localparam int unsigned DUMP_WORDS = 2;
    localparam int unsigned BW         = $clog2(MAX_BYTES + 1);

    logic clk = 1'b0;
    logic rst, start, byte_valid, byte_last, byte_ready;
    logic mem_own, mem_re, core_rst, core_clk_en, busy, done, dump_valid;
    logic [7:0]         byte_data;
    logic [AW-1:0]      mem_addr, dump_addr;
    logic [LANES-1:0]   mem_we;
    logic [8*LANES-1:0] mem_wdata, mem_rdata, dump_data;
    logic [BW-1:0]      bytes_loaded;
    logic [31:0]        cycle_count;
    logic               scramble;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prog_loader #(
        .LANES      (LANES),
        .AW         (AW),
        .MAX_BYTES  (MAX_BYTES),
        .RUN_CYCLES (RUN_CYCLES),
        .DUMP_BASE  (DUMP_BASE),
        .DUMP_WORDS (DUMP_WORDS),
        .CLEAR_EN   (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_last    (byte_last),
        .byte_ready   (byte_ready),
        .mem_own      (mem_own),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .core_rst     (core_rst),
        .core_clk_en  (core_clk_en),
        .busy         (busy),
        .done         (done),
        .dump_valid   (dump_valid),
        .dump_addr    (dump_addr),
        .dump_data    (dump_data),
        .bytes_loaded (bytes_loaded),
        .cycle_count  (cycle_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-lane memory seen by the loader; scramble fills it with junk so clearing is visible.
    logic [7:0] tmem [WORDS][LANES];
    always @(posedge clk) begin
        if (scramble) begin
            for (int w = 0; w < int'(WORDS); w++)
                for (int l = 0; l < int'(LANES); l++) tmem[w][l] <= 8'($urandom);
        end else if (mem_own) begin
            for (int l = 0; l < int'(LANES); l++)
                if (mem_we[l]) tmem[mem_addr][l] <= mem_wdata[8*l +: 8];
        end
        if (mem_re)
            for (int l = 0; l < int'(LANES); l++) mem_rdata[8*l +: 8] <= tmem[mem_addr][l];
    end

    function automatic logic [31:0] mem_word(input int w);
        logic [31:0] r;
        for (int l = 0; l < int'(LANES); l++) r[8*l +: 8] = tmem[w][l];
        return r;
    endfunction

    // Reference: after a cleared load of n bytes, byte i sits at word i/LANES lane i%LANES.
    logic [7:0] img [512];
    function automatic logic [31:0] model_word(input int w, input int n);
        logic [31:0] r;
        for (int l = 0; l < int'(LANES); l++) begin
            int idx;
            idx = w * int'(LANES) + l;
            r[8*l +: 8] = (idx < n) ? img[idx] : 8'h00;
        end
        return r;
    endfunction

    logic [AW-1:0]    exp_addr_q [$];
    logic [31:0]      exp_data_q [$];
    int               clr_next    = 0;
    int               clr_writes  = 0;
    int               load_writes = 0;
    int               en_cycles   = 0;
    logic [AW-1:0]    last_addr   = '0;
    logic [LANES-1:0] last_we     = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_own && mem_we == '1) begin
                chk("clear_addr", 64'(mem_addr), 64'(clr_next));
                chk("clear_data", 64'(mem_wdata), 64'(0));
                clr_next = (clr_next + 1) % int'(WORDS);
                clr_writes++;
            end else if (mem_own && $onehot(mem_we)) begin
                load_writes++;
                last_addr = mem_addr;
                last_we   = mem_we;
            end
            if (mem_we != '0) chk("write_while_core_owns", 64'(mem_own), 64'(1));
            if (core_clk_en) begin
                en_cycles++;
                chk("core_rst_in_run", 64'(core_rst), 64'(0));
                chk("mem_own_in_run", 64'(mem_own), 64'(0));
            end
            if (dump_valid) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_dump", 64'(dump_addr), 64'(1 << AW));
                end else begin
                    logic [AW-1:0] ea;
                    logic [31:0]   ed;
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    chk("dump_addr", 64'(dump_addr), 64'(ea));
                    chk("dump_data", 64'(dump_data), 64'(ed));
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_run(input string tag, input int len, input bit with_last,
                          input bit poke_start);
        int n, acc, i, guard, en0, ld0, clr0;
        n    = (len < int'(MAX_BYTES)) ? len : int'(MAX_BYTES);
        en0  = en_cycles;
        ld0  = load_writes;
        clr0 = clr_writes;
        @(posedge clk); #1 scramble = 1'b1;
        @(posedge clk); #1 scramble = 1'b0;
        for (int k = 0; k < int'(DUMP_WORDS); k++) begin
            exp_addr_q.push_back(AW'(int'(DUMP_BASE) + k));
            exp_data_q.push_back(model_word(int'(DUMP_BASE) + k, n));
        end
        pulse_start();
        i = 0; acc = 0; guard = 0;
        while (i < len && guard < 5000) begin
            byte_valid = ($urandom_range(3) != 0);
            byte_data  = img[i];
            byte_last  = with_last && (i == len - 1);
            @(negedge clk);
            if (byte_valid && byte_ready) begin
                i++;
                acc++;
            end else if (acc > 0 && !byte_ready) begin
                break;
            end
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 5000) chk({tag, "_stream_timeout"}, 64'(acc), 64'(n));
        byte_valid = 1'b1;
        byte_last  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk({tag, "_ready_after_end"}, 64'(byte_ready), 64'(0));
        end
        byte_valid = 1'b0;
        if (poke_start) begin
            guard = 0;
            while (!core_clk_en && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            pulse_start();
        end
        guard = 0;
        while (!done && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_core_rst"}, 64'(core_rst), 64'(1));
        chk({tag, "_bytes_loaded"}, 64'(bytes_loaded), 64'(n));
        chk({tag, "_load_writes"}, 64'(load_writes - ld0), 64'(n));
        chk({tag, "_clear_writes"}, 64'(clr_writes - clr0), 64'(WORDS));
        chk({tag, "_run_cycles"}, 64'(en_cycles - en0), 64'(RUN_CYCLES));
        chk({tag, "_cycle_count"}, 64'(cycle_count), 64'(RUN_CYCLES));
        chk({tag, "_dumps_left"}, 64'(exp_addr_q.size()), 64'(0));
        for (int w = 0; w < int'(WORDS); w++)
            chk({tag, "_mem_word"}, 64'(mem_word(w)), 64'(model_word(w, n)));
    endtask

    initial begin
        int acc, guard;
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = '0; byte_last = 1'b0;
        scramble = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_core_rst", 64'(core_rst), 64'(1));
        chk("rst_mem_own", 64'(mem_own), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_byte_ready", 64'(byte_ready), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_core_clk_en", 64'(core_clk_en), 64'(0));
        chk("rst_bytes_loaded", 64'(bytes_loaded), 64'(0));
        chk("rst_cycle_count", 64'(cycle_count), 64'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Image with last marker; words 64/65 carry known patterns.
        for (int k = 0; k < 512; k++) img[k] = 8'($urandom);
        {img[259], img[258], img[257], img[256]} = 32'hDEADBEEF;
        {img[263], img[262], img[261], img[260]} = 32'h12345678;
        do_run("last300", 300, 1'b1, 1'b1);

        // No last marker: the byte limit ends the load.
        for (int k = 0; k < 512; k++) img[k] = 8'($urandom);
        do_run("limit", 500, 1'b0, 1'b0);
        chk("limit_last_addr", 64'(last_addr), 64'(104));
        chk("limit_last_lane", 64'(last_we), 64'(4'b1000));

        for (int k = 0; k < 8; k++) img[k] = 8'(k + 1);
        do_run("short8", 8, 1'b1, 1'b0);
        chk("short8_word0", 64'(mem_word(0)), 64'(32'h04030201));
        chk("short8_word1", 64'(mem_word(1)), 64'(32'h08070605));

        // Reset while loading, right after the fifth byte is taken.
        pulse_start();
        byte_valid = 1'b1;
        acc = 0; guard = 0;
        while (acc < 5 && guard < 2000) begin
            byte_data = 8'($urandom);
            img[acc]  = byte_data;
            @(negedge clk);
            if (byte_ready) acc++;
            @(posedge clk); #1;
            guard++;
        end
        chk("abort_bytes_taken", 64'(acc), 64'(5));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_core_rst", 64'(core_rst), 64'(1));
        chk("abort_byte_ready", 64'(byte_ready), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_mem_own", 64'(mem_own), 64'(1));
        chk("abort_bytes_loaded", 64'(bytes_loaded), 64'(0));
        chk("abort_cycle_count", 64'(cycle_count), 64'(0));
        chk("abort_partial_word0", 64'(mem_word(0)), 64'(model_word(0, 5)));
        chk("abort_partial_lane4", 64'(tmem[1][0]), 64'(img[4]));
        byte_valid = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_after_abort", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
